// File: rtl/switch_pkt_tx.sv
// Byte-serial packet transmitter for the switch ingress port: frames DA, SA,
// LEN, buffered payload and a trailing XOR FCS under ready/valid flow control.
//
// state | meaning
// IDLE  | waiting for start; header accepted on start && start_ready
// DA    | presenting destination address (tx_sop)
// SA    | presenting source address
// LEN   | presenting payload length
// PAY   | presenting FIFO head; stalls with underrun while FIFO is empty
// FCS   | presenting XOR accumulator (tx_eop)
// GAP   | GAP idle cycles before the next start is accepted
module switch_pkt_tx #(
  parameter int DEPTH = 8,
  parameter int GAP   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       start_ready,
  input  logic [7:0] da,
  input  logic [7:0] sa,
  input  logic [7:0] len,
  input  logic       pay_valid,
  input  logic [7:0] pay_data,
  output logic       pay_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_sop,
  output logic       tx_eop,
  input  logic       tx_ready,
  output logic       busy,
  output logic       underrun,
  input  logic       scan_in0,
  input  logic       scan_en,
  input  logic       test_mode,
  output logic       scan_out0
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {S_IDLE, S_DA, S_SA, S_LEN, S_PAY, S_FCS, S_GAP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      da_q, sa_q, len_q, acc, pay_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [7:0]      fifo_head;
  logic            fifo_empty, accept, xfer, push, pop;
  logic            unused_scan;

  assign unused_scan = ^{scan_in0, scan_en, test_mode};
  assign scan_out0   = 1'b0;

  assign fifo_empty  = (count == '0);
  assign fifo_head   = mem[rd_ptr];
  assign pay_ready   = (count != (AW+1)'(DEPTH));
  assign start_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign underrun    = (state == S_PAY) && fifo_empty;
  assign accept      = start && start_ready;
  assign xfer        = tx_valid && tx_ready;
  assign push        = pay_valid && pay_ready;
  assign pop         = (state == S_PAY) && xfer;

  // Outputs depend only on state, latched header and FIFO flags/head.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    case (state)
      S_DA:  begin tx_valid = 1'b1; tx_data = da_q; tx_sop = 1'b1; end
      S_SA:  begin tx_valid = 1'b1; tx_data = sa_q;  end
      S_LEN: begin tx_valid = 1'b1; tx_data = len_q; end
      S_PAY: begin
        tx_valid = !fifo_empty;
        tx_data  = fifo_empty ? 8'h00 : fifo_head;
      end
      S_FCS: begin tx_valid = 1'b1; tx_data = acc; tx_eop = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_DA;
      S_DA:   if (xfer) state_nxt = S_SA;
      S_SA:   if (xfer) state_nxt = S_LEN;
      S_LEN:  if (xfer) state_nxt = (len_q == 8'd0) ? S_FCS : S_PAY;
      S_PAY:  if (xfer && (pay_cnt + 8'd1 == len_q)) state_nxt = S_FCS;
      S_FCS:  if (xfer) state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (gap_cnt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      da_q    <= '0;
      sa_q    <= '0;
      len_q   <= '0;
      acc     <= '0;
      pay_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (accept) begin
        da_q    <= da;
        sa_q    <= sa;
        len_q   <= len;
        acc     <= da ^ sa ^ len;
        pay_cnt <= '0;
      end else if (pop) begin
        acc     <= acc ^ fifo_head;
        pay_cnt <= pay_cnt + 8'd1;
      end
      if ((state == S_FCS) && xfer)
        gap_cnt <= GW'(GAP - 1);
      else if ((state == S_GAP) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Storage is not reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pay_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_pkt_tx.sv
// Scoreboard bench for switch_pkt_tx: expected frame bytes are queued at start
// time from a payload model and popped as the DUT transfers bytes.
module tb_switch_pkt_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       start_ready;
  logic [7:0] da, sa, len;
  logic       pay_valid;
  logic [7:0] pay_data;
  logic       pay_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_sop, tx_eop;
  logic       tx_ready = 1'b1;
  logic       busy, underrun;
  logic       scan_in0, scan_en, test_mode;
  logic       scan_out0;

  int n_vec = 0;
  int n_err = 0;
  int und_cnt = 0;
  bit bp_mode = 1'b0;

  logic [9:0] exp_q [$];
  logic [7:0] mdl_fifo [$];

  logic       prev_stall = 1'b0;
  logic [9:0] prev_out;

  switch_pkt_tx #(.DEPTH(8), .GAP(2)) dut (
    .clk(clk), .reset(reset), .start(start), .start_ready(start_ready),
    .da(da), .sa(sa), .len(len), .pay_valid(pay_valid), .pay_data(pay_data),
    .pay_ready(pay_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_ready(tx_ready), .busy(busy),
    .underrun(underrun), .scan_in0(scan_in0), .scan_en(scan_en),
    .test_mode(test_mode), .scan_out0(scan_out0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #2;
    tx_ready = bp_mode ? ~tx_ready : 1'b1;
  end

  // Transfer monitor: pops the scoreboard and checks hold-while-stalled.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (underrun) und_cnt++;
      if (prev_stall) begin
        chk("hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("hold_byte", {22'd0, tx_sop, tx_eop, tx_data}, {22'd0, prev_out});
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", {22'd0, tx_sop, tx_eop, tx_data}, 32'hFFFF);
        else chk("tx_byte", {22'd0, tx_sop, tx_eop, tx_data}, {22'd0, exp_q.pop_front()});
      end
      prev_stall = tx_valid && !tx_ready;
      prev_out   = {tx_sop, tx_eop, tx_data};
    end
  end

  task automatic push_byte(input logic [7:0] b);
    logic acc_ok;
    acc_ok = (mdl_fifo.size() < 8);
    pay_valid = 1'b1;
    pay_data  = b;
    chk("pay_ready", {31'd0, pay_ready}, {31'd0, acc_ok});
    tick();
    if (acc_ok) mdl_fifo.push_back(b);
    pay_valid = 1'b0;
  endtask

  task automatic start_pkt(input logic [7:0] d, input logic [7:0] s, input logic [7:0] l);
    logic [7:0] f, b;
    int n = 0;
    while (!start_ready && n < 200) begin tick(); n++; end
    chk("start_wait", {31'd0, start_ready}, 32'd1);
    f = d ^ s ^ l;
    exp_q.push_back({2'b10, d});
    exp_q.push_back({2'b00, s});
    exp_q.push_back({2'b00, l});
    for (int i = 0; i < int'(l); i++) begin
      b = (mdl_fifo.size() != 0) ? mdl_fifo.pop_front() : 8'h00;
      f = f ^ b;
      exp_q.push_back({2'b00, b});
    end
    exp_q.push_back({2'b01, f});
    start = 1'b1; da = d; sa = s; len = l;
    tick();
    start = 1'b0; da = 8'h00; sa = 8'h00; len = 8'h00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!start_ready || exp_q.size() != 0) && n < 300) begin tick(); n++; end
    chk("frame_done", exp_q.size(), 0);
    chk("idle_after", {31'd0, start_ready}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start_ready"}, {31'd0, start_ready}, 32'd1);
    chk({tag, "_busy"},        {31'd0, busy}, 32'd0);
    chk({tag, "_tx"}, {21'd0, tx_valid, tx_sop, tx_eop, tx_data}, 32'd0);
    chk({tag, "_pay_ready"},   {31'd0, pay_ready}, 32'd1);
    chk({tag, "_underrun"},    {31'd0, underrun}, 32'd0);
    chk({tag, "_scan_out0"},   {31'd0, scan_out0}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; da = '0; sa = '0; len = '0;
    pay_valid = 1'b0; pay_data = '0;
    scan_in0 = 1'b0; scan_en = 1'b0; test_mode = 1'b0;
    #3;
    chk_reset_outputs("por");
    tick();
    reset = 1'b1;
    tick();

    // Basic frame with exact cycle timing and gap
    foreach (mdl_fifo[i]) ;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    start_pkt(8'h01, 8'h02, 8'h04);
    chk("da_latency", {30'd0, tx_valid, tx_sop}, 32'd3);
    chk("busy", {31'd0, busy}, 32'd1);
    chk("start_ready_busy", {31'd0, start_ready}, 32'd0);
    repeat (8) tick();
    chk("frame_8cyc", exp_q.size(), 0);
    chk("gap1_idle", {30'd0, start_ready, tx_valid}, 32'd0);
    tick();
    chk("gap2_idle", {30'd0, start_ready, tx_valid}, 32'd0);
    tick();
    chk("gap_done", {31'd0, start_ready}, 32'd1);

    // Zero length leaves a prefilled byte in the FIFO
    push_byte(8'h99);
    start_pkt(8'hA5, 8'h5A, 8'h00);
    wait_idle();

    // Fill FIFO to 8 (0x99 + 7), 9th push dropped, then drain all 8
    for (int i = 1; i <= 7; i++) push_byte(8'hC0 + 8'(i));
    push_byte(8'hEE);
    start_pkt(8'h10, 8'h20, 8'h08);
    wait_idle();
    chk("fifo_empty_after", {31'd0, pay_ready}, 32'd1);

    // Backpressure on the basic frame
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    bp_mode = 1'b1;
    start_pkt(8'h01, 8'h02, 8'h04);
    wait_idle();
    bp_mode = 1'b0;
    tick(); tick();

    // Underrun: empty FIFO, one byte every 4th cycle
    und_cnt = 0;
    mdl_fifo.push_back(8'h81); mdl_fifo.push_back(8'h82); mdl_fifo.push_back(8'h83);
    start_pkt(8'h0F, 8'hF0, 8'h03);
    for (int i = 0; i < 3; i++) begin
      repeat (3) tick();
      pay_valid = 1'b1;
      pay_data  = 8'h81 + 8'(i);
      tick();
      pay_valid = 1'b0;
    end
    wait_idle();
    chk("underrun_cnt", und_cnt, 7);

    // Reset after the SA transfer
    push_byte(8'h5C); push_byte(8'h5D);
    start_pkt(8'h3C, 8'hC3, 8'h02);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    mdl_fifo.delete();
    tick();
    reset = 1'b1;
    tick();
    push_byte(8'h71);
    start_pkt(8'h33, 8'h44, 8'h01);
    chk("post_rst_sop", {30'd0, tx_valid, tx_sop}, 32'd3);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
